// File: rtl/tour_swap_scheduler_if.sv
// ---------------------------------------------------------------------------
// tour_swap_scheduler_if
//   Bundles the two buses the scheduler drives: the city-coordinate ROM port
//   and the adjacent-swap checker port.
//   master (scheduler side):
//     coord_addr  out  ROM address (IDX_W bits)
//     coord_x/y   in   ROM data, valid the cycle after coord_addr
//     chk_rst     out  active-high checker reset
//     chk_pts     out  {x1,y1,x2,y2,x3,y3,x4,y4}
//     chk_res     in   1 = swapped order is shorter
//     chk_complete in  checker result valid (level)
//     chk_diff    in   checker sum1 - sum2
//   slave: the same signals seen from the ROM/checker side.
// ---------------------------------------------------------------------------
interface tour_swap_scheduler_if #(
  parameter int IDX_W = 4
);
  logic [IDX_W-1:0] coord_addr;
  logic [7:0]       coord_x;
  logic [7:0]       coord_y;
  logic             chk_rst;
  logic [63:0]      chk_pts;
  logic             chk_res;
  logic             chk_complete;
  logic [18:0]      chk_diff;

  modport master (
    output coord_addr, chk_rst, chk_pts,
    input  coord_x, coord_y, chk_res, chk_complete, chk_diff
  );

  modport slave (
    input  coord_addr, chk_rst, chk_pts,
    output coord_x, coord_y, chk_res, chk_complete, chk_diff
  );
endinterface

// File: rtl/tour_swap_scheduler.sv
// ---------------------------------------------------------------------------
// tour_swap_scheduler
//   Runs 2-opt style adjacent swaps over a cyclic tour of N cities. For each
//   position p the coordinates of tour[p..p+3] (mod N) are fetched from the
//   city ROM, handed to the checker, and tour[p+1]/tour[p+2] are exchanged
//   when the checker reports the swapped order shorter. Passes repeat until
//   one makes no swap or MAX_PASSES passes have run.
//   Ports:
//     clk, rst (sync, active-low)
//     start  in   begin a run (accepted in IDLE only)
//     busy   out  run in progress
//     done   out  one-cycle pulse at run end
//     err    out  sticky checker-timeout flag for this run
//     bus    master side of the ROM/checker interface
//     rd_pos in / rd_city out  combinational tour readout
//     swap_cnt, total_gain, pass_cnt  run statistics (saturating)
// ---------------------------------------------------------------------------
module tour_swap_scheduler #(
  parameter int N          = 16,
  parameter int IDX_W      = 4,
  parameter int MAX_PASSES = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  tour_swap_scheduler_if.master     bus,
  input  logic [IDX_W-1:0]          rd_pos,
  output logic [IDX_W-1:0]          rd_city,
  output logic [15:0]               swap_cnt,
  output logic [23:0]               total_gain,
  output logic [7:0]                pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CLR, S_WAIT, S_UPDATE, S_DONE
  } state_t;

  localparam int               DEPTH     = 2**IDX_W;
  localparam logic [IDX_W+1:0] N_W       = (IDX_W+2)'(N);
  localparam logic [IDX_W-1:0] LAST_P    = IDX_W'(N-1);
  localparam logic [8:0]       MAXP_W    = 9'(MAX_PASSES);
  localparam int               WAIT_W    = $clog2(TIMEOUT+1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT-1);

  // (base + ofs) mod N; base < N and ofs <= 3 <= N-1, so one subtract suffices.
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                               input logic [1:0] ofs);
    logic [IDX_W+1:0] s;
    s = {2'b00, base} + {{IDX_W{1'b0}}, ofs};
    if (s >= N_W) s = s - N_W;
    return s[IDX_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  p_q, p_d;
  logic [2:0]        fc_q, fc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              hit_q, hit_d;
  logic [18:0]       diff_q, diff_d;
  logic              dirty_q, dirty_d;
  logic              err_q, err_d;
  logic [15:0]       swap_q, swap_d;
  logic [23:0]       gain_q, gain_d;
  logic [7:0]        pass_q, pass_d;
  logic [63:0]       pts_q, pts_d;
  logic [IDX_W-1:0]  tour_q [DEPTH];
  logic [IDX_W-1:0]  tour_d [DEPTH];

  logic [IDX_W-1:0]  fetch_idx, swap_a, swap_b;
  logic [24:0]       gain_sum;
  logic              pass_dirty;

  assign fetch_idx  = idx_add(p_q, fc_q[1:0]);
  assign swap_a     = idx_add(p_q, 2'd1);
  assign swap_b     = idx_add(p_q, 2'd2);
  assign gain_sum   = {1'b0, gain_q} + {6'd0, diff_q};
  assign pass_dirty = dirty_q | hit_q;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    fc_d    = fc_q;
    wait_d  = wait_q;
    hit_d   = hit_q;
    diff_d  = diff_q;
    dirty_d = dirty_q;
    err_d   = err_q;
    swap_d  = swap_q;
    gain_d  = gain_q;
    pass_d  = pass_q;
    pts_d   = pts_q;
    tour_d  = tour_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          swap_d  = '0;
          gain_d  = '0;
          pass_d  = '0;
          p_d     = '0;
          fc_d    = '0;
          dirty_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Address goes out on cycles 0..3; ROM data lands one cycle later.
        fc_d = fc_q + 3'd1;
        case (fc_q)
          3'd1: pts_d[63:48] = {bus.coord_x, bus.coord_y};
          3'd2: pts_d[47:32] = {bus.coord_x, bus.coord_y};
          3'd3: pts_d[31:16] = {bus.coord_x, bus.coord_y};
          3'd4: begin
            pts_d[15:0] = {bus.coord_x, bus.coord_y};
            fc_d        = '0;
            state_d     = S_CLR;
          end
          default: ;
        endcase
      end
      S_CLR: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Result is latched here so UPDATE does not depend on the checker
        // still holding it.
        if (bus.chk_complete) begin
          hit_d   = bus.chk_res;
          diff_d  = bus.chk_diff;
          state_d = S_UPDATE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          hit_d   = 1'b0;
          state_d = S_UPDATE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_UPDATE: begin
        if (hit_q) begin
          tour_d[swap_a] = tour_q[swap_b];
          tour_d[swap_b] = tour_q[swap_a];
          swap_d  = (swap_q == '1) ? swap_q : swap_q + 16'd1;
          gain_d  = gain_sum[24] ? '1 : gain_sum[23:0];
          dirty_d = 1'b1;
        end
        fc_d = '0;
        if (p_q != LAST_P) begin
          p_d     = p_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          pass_d = (pass_q == '1) ? pass_q : pass_q + 8'd1;
          if (!pass_dirty || ({1'b0, pass_q} + 9'd1 >= MAXP_W)) begin
            state_d = S_DONE;
          end else begin
            p_d     = '0;
            dirty_d = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      fc_q    <= '0;
      wait_q  <= '0;
      hit_q   <= 1'b0;
      diff_q  <= '0;
      dirty_q <= 1'b0;
      err_q   <= 1'b0;
      swap_q  <= '0;
      gain_q  <= '0;
      pass_q  <= '0;
      pts_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      fc_q    <= fc_d;
      wait_q  <= wait_d;
      hit_q   <= hit_d;
      diff_q  <= diff_d;
      dirty_q <= dirty_d;
      err_q   <= err_d;
      swap_q  <= swap_d;
      gain_q  <= gain_d;
      pass_q  <= pass_d;
      pts_q   <= pts_d;
    end
  end

  // Entries at and above N are never addressed and simply keep identity.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tour
    always_ff @(posedge clk) begin
      if (!rst) tour_q[gi] <= IDX_W'(gi);
      else      tour_q[gi] <= tour_d[gi];
    end
  end

  assign bus.coord_addr = (state_q == S_FETCH && !fc_q[2]) ? tour_q[fetch_idx] : '0;
  assign bus.chk_rst    = (state_q != S_WAIT);
  assign bus.chk_pts    = pts_q;

  assign busy       = (state_q == S_FETCH) || (state_q == S_CLR) ||
                      (state_q == S_WAIT)  || (state_q == S_UPDATE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign swap_cnt   = swap_q;
  assign total_gain = gain_q;
  assign pass_cnt   = pass_q;
  assign rd_city    = tour_q[rd_pos];

endmodule

// File: tb/tb_tour_swap_scheduler.sv
module tb_tour_swap_scheduler;
  localparam int N  = 4;
  localparam int IW = 4;
  localparam int MP = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [IW-1:0] rd_pos = '0;
  logic [IW-1:0] rd_city;
  logic [15:0]   swap_cnt;
  logic [23:0]   total_gain;
  logic [7:0]    pass_cnt;

  tour_swap_scheduler_if #(.IDX_W(IW)) bus ();

  tour_swap_scheduler #(.N(N), .IDX_W(IW), .MAX_PASSES(MP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .bus(bus), .rd_pos(rd_pos), .rd_city(rd_city), .swap_cnt(swap_cnt),
    .total_gain(total_gain), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // City ROM, one-cycle registered read.
  logic [7:0] rom_x [16];
  logic [7:0] rom_y [16];
  always @(posedge clk) begin
    bus.coord_x <= rom_x[bus.coord_addr];
    bus.coord_y <= rom_y[bus.coord_addr];
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Checker behaviour: Manhattan length of p1-p2-p3-p4 vs p1-p3-p2-p4.
  // Mode 2 forces "shorter" with an arbitrary positive gain.
  function automatic logic [19:0] eval(input logic [63:0] pts, input int md);
    int x[4], y[4], s1, s2;
    for (int k = 0; k < 4; k++) begin
      x[k] = int'(pts[63-16*k -: 8]);
      y[k] = int'(pts[55-16*k -: 8]);
    end
    s1 = iabs(x[0]-x[1]) + iabs(y[0]-y[1]) + iabs(x[1]-x[2]) + iabs(y[1]-y[2])
       + iabs(x[2]-x[3]) + iabs(y[2]-y[3]);
    s2 = iabs(x[0]-x[2]) + iabs(y[0]-y[2]) + iabs(x[2]-x[1]) + iabs(y[2]-y[1])
       + iabs(x[1]-x[3]) + iabs(y[1]-y[3]);
    if (md == 2) return {1'b1, 19'(x[0] + y[3] + 1)};
    return {(s2 < s1), 19'(s1 - s2)};
  endfunction

  // Checker stub: mode 0 normal, 1 never completes, 2 always "shorter".
  int ck_mode = 0;
  int ck_lat  = 9;
  bit ck_rand = 1'b0;
  int ck_cnt  = 0;
  int cur_lat = 9;
  logic [19:0] ck_r;
  always @(posedge clk) begin
    if (bus.chk_rst) begin
      ck_cnt           <= 0;
      bus.chk_complete <= 1'b0;
      bus.chk_res      <= 1'b0;
      bus.chk_diff     <= '0;
      cur_lat          <= ck_rand ? int'($urandom_range(1, 40)) : ck_lat;
    end else begin
      ck_cnt <= ck_cnt + 1;
      if (ck_mode != 1 && ck_cnt == cur_lat - 1) begin
        ck_r = eval(bus.chk_pts, ck_mode);
        bus.chk_complete <= 1'b1;
        bus.chk_res      <= ck_r[19];
        bus.chk_diff     <= ck_r[18:0];
      end
    end
  end

  // Reference model: the swap algorithm over a plain array.
  int m_tour [N];
  int e_sw, e_gain, e_pass, e_err, e_cyc;

  task automatic model_run(input int md, input int wl);
    logic [63:0] pts;
    logic [19:0] r;
    int c, w, t, a, b;
    bit dirty, fin;
    e_sw = 0; e_gain = 0; e_pass = 0; e_err = 0; e_cyc = 0; fin = 0;
    while (!fin) begin
      dirty = 0;
      for (int p = 0; p < N; p++) begin
        for (int k = 0; k < 4; k++) begin
          c = m_tour[(p+k) % N];
          pts[63-16*k -: 16] = {rom_x[c], rom_y[c]};
        end
        w = (md == 1 || wl + 1 > TO) ? TO : wl + 1;
        e_cyc += 7 + w;
        if (md == 1 || wl + 1 > TO) begin
          e_err = 1;
        end else begin
          r = eval(pts, md);
          if (r[19]) begin
            a = (p+1) % N; b = (p+2) % N;
            t = m_tour[a]; m_tour[a] = m_tour[b]; m_tour[b] = t;
            if (e_sw < 65535) e_sw++;
            e_gain = e_gain + int'(r[18:0]);
            if (e_gain > 24'hFFFFFF) e_gain = 24'hFFFFFF;
            dirty = 1;
          end
        end
      end
      e_pass++;
      if (!dirty || e_pass >= MP) fin = 1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < N; k++) m_tour[k] = k;
  endtask

  task automatic load_rom(input int sel);
    for (int k = 0; k < 16; k++) begin
      rom_x[k] = 8'($urandom_range(0, 255));
      rom_y[k] = 8'($urandom_range(0, 255));
    end
    if (sel == 1) begin  // square in tour order
      rom_x[0] = 0;  rom_y[0] = 0;  rom_x[1] = 10; rom_y[1] = 0;
      rom_x[2] = 10; rom_y[2] = 10; rom_x[3] = 0;  rom_y[3] = 10;
    end else if (sel == 2) begin  // crossed: 1 and 2 out of order
      rom_x[0] = 0;  rom_y[0] = 0;  rom_x[1] = 10; rom_y[1] = 10;
      rom_x[2] = 10; rom_y[2] = 0;  rom_x[3] = 0;  rom_y[3] = 10;
    end
  endtask

  // Starts a run and follows it to done; inject>=0 pulses start while busy.
  int r_cyc, r_dp, r_seen, r_busy_at_done;
  task automatic do_run(input int inject);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    r_cyc = 0; r_dp = 0; r_seen = 0; r_busy_at_done = 0;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        r_seen = 1; r_dp++; r_busy_at_done = int'(busy);
        break;
      end
      if (busy) r_cyc++;
      start = (i == inject);
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) r_dp++;
    end
    n_vec++;
    if (r_seen == 0) begin
      n_bad++;
      $display("FAIL run_timeout: done never seen, required within 20000 cycles");
    end
  endtask

  task automatic check_tour(input string tag);
    for (int k = 0; k < N; k++) begin
      rd_pos = IW'(k);
      #1;
      n_vec++;
      if (rd_city !== IW'(m_tour[k])) begin
        n_bad++;
        $display("FAIL %s_tour[%0d]: got %0d required %0d", tag, k, rd_city, m_tour[k]);
      end
    end
  endtask

  task automatic check_results(input string tag, input bit chk_cyc);
    n_vec += 6;
    if (swap_cnt !== 16'(e_sw)) begin n_bad++;
      $display("FAIL %s_swap_cnt: got %0d required %0d", tag, swap_cnt, e_sw); end
    if (total_gain !== 24'(e_gain)) begin n_bad++;
      $display("FAIL %s_total_gain: got %0d required %0d", tag, total_gain, e_gain); end
    if (pass_cnt !== 8'(e_pass)) begin n_bad++;
      $display("FAIL %s_pass_cnt: got %0d required %0d", tag, pass_cnt, e_pass); end
    if (err !== 1'(e_err)) begin n_bad++;
      $display("FAIL %s_err: got %0b required %0d", tag, err, e_err); end
    if (r_dp != 1) begin n_bad++;
      $display("FAIL %s_done_pulses: got %0d required 1", tag, r_dp); end
    if (r_busy_at_done != 0) begin n_bad++;
      $display("FAIL %s_busy_at_done: got %0d required 0", tag, r_busy_at_done); end
    if (chk_cyc) begin
      n_vec++;
      if (r_cyc != e_cyc) begin n_bad++;
        $display("FAIL %s_busy_cycles: got %0d required %0d", tag, r_cyc, e_cyc); end
    end
    check_tour(tag);
    $display("run %s: swaps=%0d gain=%0d passes=%0d err=%0b busy_cycles=%0d",
             tag, swap_cnt, total_gain, pass_cnt, err, r_cyc);
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec += 6;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done); end
    if (bus.chk_rst !== 1'b1) begin n_bad++;
      $display("FAIL reset_chk_rst: got %b required 1", bus.chk_rst); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b required 0", err); end
    if (bus.chk_pts !== 64'd0) begin n_bad++;
      $display("FAIL reset_chk_pts: got %h required 0", bus.chk_pts); end
    if ({swap_cnt, total_gain, pass_cnt} !== 48'd0) begin n_bad++;
      $display("FAIL reset_counters: got %0d/%0d/%0d required 0/0/0", swap_cnt, total_gain, pass_cnt); end
    check_tour("reset");
    $display("reset: tour identity, busy=%b done=%b chk_rst=%b", busy, done, bus.chk_rst);
  endtask

  task automatic test_square();
    load_rom(1); ck_mode = 0; ck_rand = 0; ck_lat = 9;
    do_run(-1);
    model_run(0, 9);
    check_results("square", 1);
    n_vec += 2;
    if (pass_cnt !== 8'd1 || swap_cnt !== 16'd0) begin n_bad++;
      $display("FAIL square_const: got passes=%0d swaps=%0d required 1/0", pass_cnt, swap_cnt); end
    if (r_cyc != 68) begin n_bad++;
      $display("FAIL square_cycles_const: got %0d required 68", r_cyc); end
  endtask

  task automatic test_crossed();
    apply_reset();
    load_rom(2); ck_mode = 0; ck_rand = 0; ck_lat = 9;
    do_run(-1);
    model_run(0, 9);
    check_results("crossed", 1);
    n_vec += 2;
    if (swap_cnt !== 16'd1 || total_gain !== 24'd20 || pass_cnt !== 8'd2) begin n_bad++;
      $display("FAIL crossed_const: got swaps=%0d gain=%0d passes=%0d required 1/20/2",
               swap_cnt, total_gain, pass_cnt); end
    rd_pos = 4'd1; #1;
    if (rd_city !== 4'd2) begin n_bad++;
      $display("FAIL crossed_tour1: got %0d required 2", rd_city); end
  endtask

  task automatic test_timeout();
    apply_reset();
    load_rom(1); ck_mode = 1; ck_rand = 0;
    do_run(-1);
    model_run(1, 0);
    check_results("timeout", 1);
    n_vec++;
    if (r_cyc != 284) begin n_bad++;
      $display("FAIL timeout_cycles_const: got %0d required 284", r_cyc); end
  endtask

  task automatic test_force();
    apply_reset();
    load_rom(1); ck_mode = 2; ck_rand = 0; ck_lat = 3;
    do_run(-1);
    model_run(2, 3);
    check_results("force", 1);
    n_vec++;
    if (pass_cnt !== 8'd8 || swap_cnt !== 16'd32) begin n_bad++;
      $display("FAIL force_const: got passes=%0d swaps=%0d required 8/32", pass_cnt, swap_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    apply_reset();
    load_rom(2); ck_mode = 0; ck_rand = 0; ck_lat = 9;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.chk_rst === 1'b0) begin found = 1; break; end
      @(negedge clk);
    end
    n_vec++;
    if (!found) begin n_bad++; $display("FAIL midwait_reach: WAIT not reached in 200 cycles"); end
    rst = 1'b0;
    @(negedge clk);
    n_vec += 3;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midwait_busy: got %b required 0", busy); end
    if (bus.chk_rst !== 1'b1) begin n_bad++;
      $display("FAIL midwait_chk_rst: got %b required 1", bus.chk_rst); end
    if (swap_cnt !== 16'd0) begin n_bad++;
      $display("FAIL midwait_swap: got %0d required 0", swap_cnt); end
    rst = 1'b1;
    for (int k = 0; k < N; k++) m_tour[k] = k;
    repeat (30) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midwait_idle: got busy %b required 0", busy); end
    check_tour("midwait");
    $display("reset in WAIT: aborted, busy=%b chk_rst=%b", busy, bus.chk_rst);
  endtask

  task automatic test_start_while_busy();
    apply_reset();
    load_rom(0); ck_mode = 0; ck_rand = 0; ck_lat = 5;
    do_run(30);
    model_run(0, 5);
    check_results("busy_start", 1);
  endtask

  task automatic test_random();
    apply_reset();
    ck_mode = 0; ck_rand = 1;
    for (int r = 0; r < 6; r++) begin
      load_rom(0);
      do_run(-1);
      model_run(0, 1);
      check_results($sformatf("rand%0d", r), 0);
    end
    ck_rand = 0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin rom_x[k] = 0; rom_y[k] = 0; end
    test_reset();
    test_square();
    test_crossed();
    test_timeout();
    test_force();
    test_reset_mid_wait();
    test_start_while_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end
endmodule
